// File: rtl/rr_mux_sched.sv
// Round-robin 4:1 data mux scheduler with burst-limited grants.
// A grant holds until MAX_BURST beats are accepted or the owner drops its request.
module rr_mux_sched #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   dout,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [3:0]         ack
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic             last_beat;
    logic             release_now;
    logic [1:0]       arb_ptr;
    logic [1:0]       win;
    logic [WIDTH-1:0] lane;

    assign lane        = din[int'(sel)*WIDTH +: WIDTH];
    assign out_valid   = (state == GRANT) & req[sel];
    assign dout        = out_valid ? lane : '0;
    assign beat        = out_valid & out_ready;
    assign ack         = gnt & {4{beat}};
    assign last_beat   = (cnt == CNT_W'(MAX_BURST - 1));
    assign release_now = (state == GRANT) & ((beat & last_beat) | ~req[sel]);

    // On release the scan starts just past the outgoing owner, making it lowest priority.
    assign arb_ptr = release_now ? sel + 2'd1 : ptr;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        win = arb_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[arb_ptr + 2'(k)]) begin
                win = arb_ptr + 2'(k);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (state == IDLE || release_now) begin
            if (release_now) begin
                ptr <= sel + 2'd1;
            end
            cnt <= '0;
            if (|req) begin
                state <= GRANT;
                sel   <= win;
                gnt   <= 4'b0001 << win;
            end else begin
                state <= IDLE;
                gnt   <= '0;
            end
        end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_mux_sched.sv
// Directed self-checking bench for rr_mux_sched: burst rotation, stalls, drops,
// mid-burst reset, and a single-beat-burst instance.
module tb_rr_mux_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  dout;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  ack;

    logic [3:0]  req1 = '0;
    logic        rdy1 = 1'b0;
    logic        out_valid1;
    logic [7:0]  dout1;
    logic [3:0]  gnt1;
    logic [1:0]  sel1;
    logic [3:0]  ack1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_mux_sched #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
        .out_valid(out_valid), .dout(dout), .gnt(gnt), .sel(sel), .ack(ack)
    );

    rr_mux_sched #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .din(din), .out_ready(rdy1),
        .out_valid(out_valid1), .dout(dout1), .gnt(gnt1), .sel(sel1), .ack(ack1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven afterwards are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset, then idle with no requests
        do_reset();
        step();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_sel", 32'(sel), 32'h0);

        // All four requesting: four beats per lane, rotation without bubbles
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        do_reset();
        #1;
        check("r29_latency", 32'(gnt), 32'h0);
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                if (g < 4 || b == 0) begin
                    step();
                    check("r29_gnt", 32'(gnt), 32'(1) << (g % 4));
                    check("r29_ack", 32'(ack), 32'(1) << (g % 4));
                end
            end
        end

        // Sole requester lane 2: continuous data, re-granted with no bubble
        req = 4'b0100;
        do_reset();
        #1;
        check("r30_latency", 32'(gnt), 32'h0);
        for (int c = 0; c < 8; c++) begin
            step();
            check("r30_gnt", 32'(gnt), 32'h4);
            check("r30_dout", 32'(dout), 32'hA5);
            check("r30_ack", 32'(ack), 32'h4);
        end

        // Lane 1 stalled for 3 cycles; stalls must not count toward the burst
        req = 4'b0010;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            req = 4'b0011;
            #1;
            check("r31_gnt", 32'(gnt), 32'h2);
            check("r31_valid", 32'(out_valid), 32'h1);
            check("r31_dout", 32'(dout), 32'h22);
            check("r31_ack_stall", 32'(ack), 32'h0);
        end
        step();
        out_ready = 1'b1;
        #1;
        check("r31_ack_pulse", 32'(ack), 32'h2);
        step();
        out_ready = 1'b0;
        #1;
        check("r31_ack_off", 32'(ack), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            out_ready = 1'b1;
            #1;
            check("r31_gnt_hold", 32'(gnt), 32'h2);
            check("r31_ack_beat", 32'(ack), 32'h2);
        end
        step();
        check("r31_rotate", 32'(gnt), 32'h1);

        // Lane 3 drops its request after two beats; lane 0 takes over
        req = 4'b1000;
        out_ready = 1'b1;
        do_reset();
        step();
        req = 4'b1001;
        #1;
        check("r32_gnt", 32'(gnt), 32'h8);
        check("r32_ack1", 32'(ack), 32'h8);
        step();
        check("r32_ack2", 32'(ack), 32'h8);
        step();
        req = 4'b0001;
        #1;
        check("r32_drop_valid", 32'(out_valid), 32'h0);
        check("r32_drop_ack", 32'(ack), 32'h0);
        check("r32_drop_dout", 32'(dout), 32'h0);
        step();
        check("r32_gnt_next", 32'(gnt), 32'h1);
        check("r32_sel_next", 32'(sel), 32'h0);
        check("r32_ack_next", 32'(ack), 32'h1);

        // Asynchronous reset in the middle of a lane-2 burst
        req = 4'b0100;
        do_reset();
        step();
        step();
        check("r33_pre_gnt", 32'(gnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("r33_async_gnt", 32'(gnt), 32'h0);
        check("r33_async_valid", 32'(out_valid), 32'h0);
        check("r33_async_ack", 32'(ack), 32'h0);
        req = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("r33_latency", 32'(gnt), 32'h0);
        step();
        check("r33_gnt", 32'(gnt), 32'h2);
        check("r33_dout", 32'(dout), 32'h22);

        // Single-beat bursts alternate between lanes 1 and 3
        req = 4'b0000;
        req1 = 4'b1010;
        rdy1 = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            check("r34_gnt", 32'(gnt1), (c % 2 == 0) ? 32'h2 : 32'h8);
            check("r34_ack", 32'(ack1), (c % 2 == 0) ? 32'h2 : 32'h8);
        end
        check("r34_other_idle", 32'(gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
